// File: rtl/multiplicador_secuencial_nucleo_pkg.sv
// Shared definitions for the sequential shift-add multiplier core.
//   estado_t        : FSM state encoding (IDLE / CALC / DONE)
//   WORD_LENGTH_DEF : default operand width
//   count_width()   : width of the iteration counter for a given operand width
package multiplicador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } estado_t;

    localparam int unsigned WORD_LENGTH_DEF = 8;

    function automatic int unsigned count_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/multiplicador_secuencial_nucleo_if.sv
// Handshake/data bundle of the multiplier core.
//   Start_Input        : request a multiplication (master -> core)
//   Multiplicand_Input : signed operand (master -> core)
//   Multiplier_Input   : signed operand (master -> core)
//   Product_Output     : unsigned product magnitude (core -> master)
//   Sign_Output        : result sign, 1 = negative (core -> master)
//   Ready_Output       : result valid level (core -> master)
//   Busy_Output        : iterating (core -> master)
interface multiplicador_secuencial_nucleo_if
    import multiplicador_pkg::*;
#(
    parameter int unsigned Word_Length = WORD_LENGTH_DEF
);

    logic                       Start_Input;
    logic [Word_Length-1:0]     Multiplicand_Input;
    logic [Word_Length-1:0]     Multiplier_Input;
    logic [2*Word_Length-1:0]   Product_Output;
    logic                       Sign_Output;
    logic                       Ready_Output;
    logic                       Busy_Output;

    modport master (
        output Start_Input, Multiplicand_Input, Multiplier_Input,
        input  Product_Output, Sign_Output, Ready_Output, Busy_Output
    );

    modport slave (
        input  Start_Input, Multiplicand_Input, Multiplier_Input,
        output Product_Output, Sign_Output, Ready_Output, Busy_Output
    );

endinterface

// File: rtl/multiplicador_secuencial_nucleo_magnitud_operando.sv
// Combinational split of a signed operand into magnitude and sign.
//   i_operando : W-bit two's-complement value
//   o_magnitud : W-bit unsigned |i_operando| (most-negative maps to 2^(W-1))
//   o_signo    : msb of i_operando
module magnitud_operando
    import multiplicador_pkg::*;
#(
    parameter int unsigned Word_Length = WORD_LENGTH_DEF
) (
    input  logic [Word_Length-1:0] i_operando,
    output logic [Word_Length-1:0] o_magnitud,
    output logic                   o_signo
);

    always_comb begin
        o_signo    = i_operando[Word_Length-1];
        o_magnitud = o_signo ? ('0 - i_operando) : i_operando;
    end

endmodule

// File: rtl/multiplicador_secuencial_nucleo.sv
// Sequential shift-add multiplier core for signed operands.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : slave side of multiplicador_secuencial_nucleo_if
//              (start/operands in; product magnitude, sign, ready, busy out)
// Operands are captured as magnitudes on a start in IDLE or DONE; the
// unsigned product {A,Q} is built over Word_Length add/shift iterations.
module multiplicador_secuencial_nucleo
    import multiplicador_pkg::*;
#(
    parameter int unsigned Word_Length = WORD_LENGTH_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    multiplicador_secuencial_nucleo_if.slave  bus
);

    localparam int unsigned         CW   = count_width(Word_Length);
    localparam logic [CW-1:0]       LAST = CW'(Word_Length - 1);

    estado_t                r_estado;
    logic [Word_Length-1:0] r_a;
    logic [Word_Length-1:0] r_q;
    logic [Word_Length-1:0] r_m;
    logic                   r_c;
    logic [CW-1:0]          r_count;
    logic                   r_sign;
    logic                   r_ready;
    logic                   r_busy;

    logic [Word_Length-1:0] w_mag_mcand;
    logic [Word_Length-1:0] w_mag_mplier;
    logic                   w_sgn_mcand;
    logic                   w_sgn_mplier;
    logic                   w_sign_cap;
    logic [Word_Length:0]   w_suma;
    logic [Word_Length-1:0] w_a_next;
    logic [Word_Length-1:0] w_q_next;

    magnitud_operando #(.Word_Length(Word_Length)) u_mag_mcand (
        .i_operando (bus.Multiplicand_Input),
        .o_magnitud (w_mag_mcand),
        .o_signo    (w_sgn_mcand)
    );

    magnitud_operando #(.Word_Length(Word_Length)) u_mag_mplier (
        .i_operando (bus.Multiplier_Input),
        .o_magnitud (w_mag_mplier),
        .o_signo    (w_sgn_mplier)
    );

    always_comb begin
        // A zero operand has zero magnitude; its product is reported positive.
        w_sign_cap = (w_sgn_mcand ^ w_sgn_mplier) & (|w_mag_mcand) & (|w_mag_mplier);
        w_suma     = r_q[0] ? ({r_c, r_a} + {1'b0, r_m}) : {r_c, r_a};
        // Right shift of {C,A,Q}: the add carry enters A's msb, A's lsb enters Q.
        w_a_next   = w_suma[Word_Length:1];
        w_q_next   = {w_suma[0], r_q[Word_Length-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado <= IDLE;
            r_a      <= '0;
            r_q      <= '0;
            r_m      <= '0;
            r_c      <= 1'b0;
            r_count  <= '0;
            r_sign   <= 1'b0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_estado)
                IDLE, DONE: begin
                    if (bus.Start_Input) begin
                        r_m      <= w_mag_mcand;
                        r_q      <= w_mag_mplier;
                        r_a      <= '0;
                        r_c      <= 1'b0;
                        r_count  <= '0;
                        r_sign   <= w_sign_cap;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_estado <= CALC;
                    end
                end
                CALC: begin
                    r_a     <= w_a_next;
                    r_q     <= w_q_next;
                    r_c     <= 1'b0;
                    r_count <= r_count + 1'b1;
                    if (r_count == LAST) begin
                        r_busy   <= 1'b0;
                        r_ready  <= 1'b1;
                        r_estado <= DONE;
                    end
                end
                default: begin
                    r_busy   <= 1'b0;
                    r_ready  <= 1'b0;
                    r_estado <= IDLE;
                end
            endcase
        end
    end

    assign bus.Product_Output = {r_a, r_q};
    assign bus.Sign_Output    = r_sign;
    assign bus.Ready_Output   = r_ready;
    assign bus.Busy_Output    = r_busy;

endmodule
